// File: rtl/vpg_timing.sv
// rtl/vpg_timing.sv - video timing generator with per-mode tables and boundary-synchronised mode switching
module vpg_timing #(
  parameter int RESET_MODE = 5,
  parameter bit IMMEDIATE  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic [3:0]  vpg_mode,
  input  logic        vpg_mode_change,
  output logic [3:0]  mode_active,
  output logic        mode_ack,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start
);

  typedef struct packed {
    logic [11:0] hact;
    logic [11:0] hfp;
    logic [11:0] hsync;
    logic [11:0] hbp;
    logic [10:0] vact;
    logic [10:0] vfp;
    logic [10:0] vsync;
    logic [10:0] vbp;
    logic        pos;
  } timing_t;

  function automatic timing_t lookup(input logic [3:0] code);
    timing_t t;
    case (code)
      4'd1:    t = '{12'd800,  12'd40,  12'd128, 12'd88,  11'd600,  11'd1,  11'd4, 11'd23, 1'b1};
      4'd2:    t = '{12'd1024, 12'd24,  12'd136, 12'd160, 11'd768,  11'd3,  11'd6, 11'd29, 1'b0};
      4'd3:    t = '{12'd1280, 12'd110, 12'd40,  12'd220, 11'd720,  11'd5,  11'd5, 11'd20, 1'b1};
      4'd4:    t = '{12'd1280, 12'd48,  12'd112, 12'd248, 11'd1024, 11'd1,  11'd3, 11'd38, 1'b1};
      4'd5:    t = '{12'd1920, 12'd88,  12'd44,  12'd148, 11'd1080, 11'd4,  11'd5, 11'd36, 1'b1};
      default: t = '{12'd640,  12'd16,  12'd96,  12'd48,  11'd480,  11'd10, 11'd2, 11'd33, 1'b0};
    endcase
    return t;
  endfunction

  localparam logic [3:0] RST_CODE = (RESET_MODE < 0 || RESET_MODE > 5) ? 4'd0 : 4'(RESET_MODE);
  localparam timing_t    RST_T    = lookup(RST_CODE);
  localparam logic       RST_IDLE = ~RST_T.pos;

  logic [11:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic [3:0]  mode_q, mode_d, pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        ack_q, ack_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic [11:0] x_q, x_d;
  logic [10:0] y_q, y_d;

  timing_t     t;
  logic [11:0] htot, hs_beg;
  logic [10:0] vtot, vs_beg;
  logic        h_last, v_last, apply, h_in_sync, v_in_sync;

  always_comb begin
    t      = lookup(mode_q);
    htot   = t.hact + t.hfp + t.hsync + t.hbp;
    vtot   = t.vact + t.vfp + t.vsync + t.vbp;
    hs_beg = t.hact + t.hfp;
    vs_beg = t.vact + t.vfp;
    h_last = (h_q == htot - 12'd1);
    v_last = (v_q == vtot - 11'd1);
    apply  = pix_en && pend_vld_q && (IMMEDIATE || (h_last && v_last));
    h_in_sync = (h_q >= hs_beg) && (h_q < hs_beg + t.hsync);
    v_in_sync = (v_q >= vs_beg) && (v_q < vs_beg + t.vsync);

    h_d = h_q;  v_d = v_q;  mode_d = mode_q;
    pend_d = pend_q;  pend_vld_d = pend_vld_q;
    ack_d = apply;
    hs_d = hs_q;  vs_d = vs_q;  de_d = de_q;  fs_d = fs_q;
    x_d = x_q;  y_d = y_q;

    // A strobe coinciding with an apply becomes the next pending request.
    if (vpg_mode_change) begin
      pend_d     = vpg_mode;
      pend_vld_d = 1'b1;
    end else if (apply) begin
      pend_vld_d = 1'b0;
    end

    if (pix_en) begin
      de_d = (h_q < t.hact) && (v_q < t.vact);
      hs_d = ~(h_in_sync ^ t.pos);
      vs_d = ~(v_in_sync ^ t.pos);
      fs_d = (h_q == 12'd0) && (v_q == 11'd0);
      x_d  = h_q;
      y_d  = v_q;
      if (apply) begin
        h_d    = 12'd0;
        v_d    = 11'd0;
        mode_d = (pend_q > 4'd5) ? 4'd0 : pend_q;
      end else if (h_last) begin
        h_d = 12'd0;
        v_d = v_last ? 11'd0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q <= '0;  v_q <= '0;  mode_q <= RST_CODE;
      pend_q <= '0;  pend_vld_q <= 1'b0;  ack_q <= 1'b0;
      hs_q <= RST_IDLE;  vs_q <= RST_IDLE;  de_q <= 1'b0;  fs_q <= 1'b0;
      x_q <= '0;  y_q <= '0;
    end else begin
      h_q <= h_d;  v_q <= v_d;  mode_q <= mode_d;
      pend_q <= pend_d;  pend_vld_q <= pend_vld_d;  ack_q <= ack_d;
      hs_q <= hs_d;  vs_q <= vs_d;  de_q <= de_d;  fs_q <= fs_d;
      x_q <= x_d;  y_q <= y_d;
    end
  end

  assign mode_active = mode_q;
  assign mode_ack    = ack_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vpg_timing.sv
// tb/tb_vpg_timing.sv - self-checking bench for vpg_timing, frame-position reference model plus mode table vectors
module tb_vpg_timing;

  localparam int HACT[6] = '{640, 800, 1024, 1280, 1280, 1920};
  localparam int HFP[6]  = '{16, 40, 24, 110, 48, 88};
  localparam int HSY[6]  = '{96, 128, 136, 40, 112, 44};
  localparam int HBP[6]  = '{48, 88, 160, 220, 248, 148};
  localparam int VACT[6] = '{480, 600, 768, 720, 1024, 1080};
  localparam int VFP[6]  = '{10, 1, 3, 5, 1, 4};
  localparam int VSY[6]  = '{2, 4, 6, 5, 3, 5};
  localparam int VBP[6]  = '{33, 23, 29, 20, 38, 36};
  localparam bit POS[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, pix_en, strobe;
  logic [3:0]  code_in;
  logic [3:0]  ma[2];
  logic        ack[2], hs[2], vs[2], de[2], fs[2];
  logic [11:0] x[2];
  logic [10:0] y[2];

  vpg_timing #(.RESET_MODE(5), .IMMEDIATE(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .vpg_mode(code_in), .vpg_mode_change(strobe),
    .mode_active(ma[0]), .mode_ack(ack[0]), .hs(hs[0]), .vs(vs[0]), .de(de[0]),
    .x(x[0]), .y(y[0]), .frame_start(fs[0]));

  vpg_timing #(.RESET_MODE(5), .IMMEDIATE(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en), .vpg_mode(code_in), .vpg_mode_change(strobe),
    .mode_active(ma[1]), .mode_ack(ack[1]), .hs(hs[1]), .vs(vs[1]), .de(de[1]),
    .x(x[1]), .y(y[1]), .frame_start(fs[1]));

  int total = 0;
  int bad   = 0;

  // Reference state: linear position within the frame rather than separate counters.
  int m_pos[2], m_mode[2], m_pend[2];
  bit m_pv[2];
  bit e_ack[2], e_hs[2], e_vs[2], e_de[2], e_fs[2];
  int e_x[2], e_y[2];

  typedef struct {
    logic [3:0] code;
    int         mode;
    int         htot;
    int         hs_lo;
    int         hs_hi;
    int         hact;
    bit         pos;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0;  m_mode[k] = 5;  m_pend[k] = 0;  m_pv[k] = 1'b0;
      e_ack[k] = 1'b0;  e_de[k] = 1'b0;  e_fs[k] = 1'b0;  e_x[k] = 0;  e_y[k] = 0;
      e_hs[k] = !POS[5];  e_vs[k] = !POS[5];
    end
  endtask

  task automatic model_step(input bit pen, input bit chg, input int cd);
    int md, ht, vt, h, v;
    bit app, hon, von;
    for (int k = 0; k < 2; k++) begin
      md  = m_mode[k];
      ht  = HACT[md] + HFP[md] + HSY[md] + HBP[md];
      vt  = VACT[md] + VFP[md] + VSY[md] + VBP[md];
      h   = m_pos[k] % ht;
      v   = m_pos[k] / ht;
      app = pen && m_pv[k] && (k == 1 || m_pos[k] == ht * vt - 1);
      e_ack[k] = app;
      if (pen) begin
        hon = (h >= HACT[md] + HFP[md]) && (h < HACT[md] + HFP[md] + HSY[md]);
        von = (v >= VACT[md] + VFP[md]) && (v < VACT[md] + VFP[md] + VSY[md]);
        e_de[k] = (h < HACT[md]) && (v < VACT[md]);
        e_hs[k] = hon ? POS[md] : !POS[md];
        e_vs[k] = von ? POS[md] : !POS[md];
        e_x[k]  = h;
        e_y[k]  = v;
        e_fs[k] = (m_pos[k] == 0);
        if (app) begin
          m_mode[k] = (m_pend[k] > 5) ? 0 : m_pend[k];
          m_pos[k]  = 0;
        end else begin
          m_pos[k] = (m_pos[k] + 1) % (ht * vt);
        end
      end
      if (chg) begin
        m_pend[k] = cd;
        m_pv[k]   = 1'b1;
      end else if (app) begin
        m_pv[k] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] av, ev;
    for (int k = 0; k < 2; k++) begin
      av = {ma[k], ack[k], hs[k], vs[k], de[k], x[k], y[k], fs[k]};
      ev = {4'(m_mode[k]), e_ack[k], e_hs[k], e_vs[k], e_de[k], 12'(e_x[k]), 11'(e_y[k]), e_fs[k]};
      chk($sformatf("dut%0d outputs{mode,ack,hs,vs,de,x,y,fs}", k), int'(av), int'(ev));
    end
  endtask

  task automatic cycle(input bit pen, input bit chg, input logic [3:0] cd);
    pix_en  = pen;
    strobe  = chg;
    code_in = cd;
    model_step(pen, chg, int'(cd));
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    int nack, guard, nr, rise0, rise1, decnt, hmin, hmax;
    bit got, pde;

    tbl[0] = '{4'd0,  0, 800,  656,  751,  640,  1'b0};
    tbl[1] = '{4'd1,  1, 1056, 840,  967,  800,  1'b1};
    tbl[2] = '{4'd2,  2, 1344, 1048, 1183, 1024, 1'b0};
    tbl[3] = '{4'd3,  3, 1650, 1390, 1429, 1280, 1'b1};
    tbl[4] = '{4'd4,  4, 1688, 1328, 1439, 1280, 1'b1};
    tbl[5] = '{4'd5,  5, 2200, 2008, 2051, 1920, 1'b1};
    tbl[6] = '{4'd9,  0, 800,  656,  751,  640,  1'b0};
    tbl[7] = '{4'd15, 0, 800,  656,  751,  640,  1'b0};

    reset_n = 1'b0;  pix_en = 1'b0;  strobe = 1'b0;  code_in = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    chk("reset mode_active", int'(ma[0]), 5);
    chk("reset hs level", int'(hs[1]), 0);
    reset_n = 1'b1;

    // FHD from reset; strobe code 0 at h=100, v=10.
    for (int i = 0; i < 10 * 2200 + 100; i++) cycle(1'b1, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 2000; i++) cycle(1'b1, 1'b0, 4'd0);
    chk("dut0 still FHD after strobe", int'(ma[0]), 5);
    chk("dut1 switched to VGA", int'(ma[1]), 0);

    for (int r = 0; r < 8; r++) begin
      cycle(1'b1, 1'b1, tbl[r].code);
      got = 1'b0;
      for (guard = 0; guard < 8 && !got; guard++) begin
        cycle(1'b1, 1'b0, 4'd0);
        got = ack[1];
      end
      chk($sformatf("vec%0d ack seen", r), int'(got), 1);
      chk($sformatf("vec%0d mode_active", r), int'(ma[1]), tbl[r].mode);
      nr = 0;  rise0 = 0;  rise1 = 0;  decnt = 0;  hmin = 4095;  hmax = -1;  pde = 1'b0;
      for (int i = 0; i < 2 * tbl[r].htot + 4; i++) begin
        cycle(1'b1, 1'b0, 4'd0);
        if (de[1] && !pde) begin
          if (nr == 0) rise0 = i;
          else if (nr == 1) rise1 = i;
          nr++;
        end
        if (de[1] && nr == 1) decnt++;
        if (hs[1] == tbl[r].pos) begin
          if (int'(x[1]) < hmin) hmin = int'(x[1]);
          if (int'(x[1]) > hmax) hmax = int'(x[1]);
        end
        pde = de[1];
      end
      chk($sformatf("vec%0d htot", r), rise1 - rise0, tbl[r].htot);
      chk($sformatf("vec%0d de per line", r), decnt, tbl[r].hact);
      chk($sformatf("vec%0d hs first x", r), hmin, tbl[r].hs_lo);
      chk($sformatf("vec%0d hs last x", r), hmax, tbl[r].hs_hi);
    end

    // Two strobes before the apply: last wins, one ack.
    nack = 0;
    cycle(1'b0, 1'b1, 4'd2);  nack += int'(ack[1]);
    cycle(1'b0, 1'b1, 4'd3);  nack += int'(ack[1]);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b0, 4'd0);
      nack += int'(ack[1]);
    end
    chk("two strobes ack count", nack, 1);
    chk("two strobes mode", int'(ma[1]), 3);

    // Strobe landing on the apply cycle stays pending.
    cycle(1'b0, 1'b1, 4'd1);
    cycle(1'b1, 1'b1, 4'd4);
    chk("overlap first apply", int'(ma[1]), 1);
    cycle(1'b1, 1'b0, 4'd0);
    chk("overlap second apply", int'(ma[1]), 4);
    chk("overlap second ack", int'(ack[1]), 1);

    for (int i = 0; i < 3000; i++) cycle(i % 3 == 0, 1'b0, 4'd0);

    for (int i = 0; i < 6000; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 499) == 0, 4'($urandom_range(0, 15)));

    // Asynchronous reset mid-frame.
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;
    for (int i = 0; i < 2000; i++) cycle(1'b1, 1'b0, 4'd0);
    chk("dut0 mode after reset", int'(ma[0]), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
